// File: rtl/nibble_serial_subtractor.sv
// ============================================================================
// Module      : nibble_serial_subtractor
// Description : Multi-cycle d = a - b, one NIBBLE slice per clock (LSB first),
//               with a ripple borrow register and sign/zero/borrow/parity/ovf.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_serial_subtractor #(
    parameter int WIDTH  = 16,
    parameter int NIBBLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             sign,
    output logic             zero,
    output logic             borrow,
    output logic             parity,
    output logic             overflow
);

    localparam int SLICES = WIDTH / NIBBLE;
    localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [IDXW-1:0]  r_idx;
    logic             r_brw;

    logic [NIBBLE-1:0] w_a_sl [SLICES];
    logic [NIBBLE-1:0] w_b_sl [SLICES];
    logic [NIBBLE:0]   w_diff;
    logic              w_bo;
    logic [WIDTH-1:0]  w_work_nxt;
    logic              w_ovf;

    // Slice views of the latched operands, and the working result with the
    // current slice merged in so the final edge can load d directly.
    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
            assign w_a_sl[gi] = r_a[gi*NIBBLE +: NIBBLE];
            assign w_b_sl[gi] = r_b[gi*NIBBLE +: NIBBLE];
            assign w_work_nxt[gi*NIBBLE +: NIBBLE] =
                (r_idx == IDXW'(gi)) ? w_diff[NIBBLE-1:0]
                                     : r_work[gi*NIBBLE +: NIBBLE];
        end
    endgenerate

    // Extra top bit of the NIBBLE+1 wide difference is the slice borrow-out.
    assign w_diff = {1'b0, w_a_sl[r_idx]} - {1'b0, w_b_sl[r_idx]}
                  - {{NIBBLE{1'b0}}, r_brw};
    assign w_bo   = w_diff[NIBBLE];

    assign w_ovf = ( r_a[WIDTH-1] & ~r_b[WIDTH-1] & ~w_work_nxt[WIDTH-1])
                 | (~r_a[WIDTH-1] &  r_b[WIDTH-1] &  w_work_nxt[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_idx    <= '0;
            r_brw    <= 1'b0;
            d        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            borrow   <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= '0;
                        r_brw <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_work <= w_work_nxt;
                    r_brw  <= w_bo;
                    r_idx  <= r_idx + 1'b1;
                    // Visible results only move on the completing edge.
                    if (r_idx == LAST_IDX) begin
                        d        <= w_work_nxt;
                        sign     <= w_work_nxt[WIDTH-1];
                        zero     <= (w_work_nxt == '0);
                        borrow   <= w_bo;
                        parity   <= ~^w_work_nxt;
                        overflow <= w_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
// Directed-vector bench for nibble_serial_subtractor: table of operand/result
// records plus hand-written sequences for handshake and reset corner cases.
`default_nettype none

module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] d;
    logic        sign;
    logic        zero;
    logic        borrow;
    logic        parity;
    logic        overflow;

    int n_chk  = 0;
    int n_pass = 0;

    nibble_serial_subtractor #(.WIDTH(16), .NIBBLE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .d        (d),
        .sign     (sign),
        .zero     (zero),
        .borrow   (borrow),
        .parity   (parity),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // {sign, zero, borrow, parity, overflow}
    logic [4:0] flags;
    assign flags = {sign, zero, borrow, parity, overflow};

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic [4:0]  f;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 32) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Launches one op from IDLE/DONE and waits for done; reports edges to done,
    // RUN cycles seen, and how many RUN cycles saw d change.
    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi,
                          output int lat, output int bcnt, output int dchg);
        logic [15:0] d0;
        @(negedge clk);
        a     = ai;
        b     = bi;
        start = 1'b1;
        d0    = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~ai;
        b     = ~bi;
        lat   = 0;
        bcnt  = 0;
        dchg  = 0;
        while (!done && lat < 32) begin
            if (busy) bcnt++;
            if (d !== d0) dchg++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dchg;
        int n;
        int ndone;

        vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 5'b00000};
        vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 5'b10110};
        vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 5'b00001};
        vecs[3] = '{16'h5A5A, 16'h5A5A, 16'h0000, 5'b01010};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 5'b10101};
        vecs[5] = '{16'h0010, 16'h0001, 16'h000F, 5'b00010};
        vecs[6] = '{16'h1000, 16'h0001, 16'h0FFF, 5'b00010};
        vecs[7] = '{16'hFFFF, 16'h0001, 16'hFFFE, 5'b10000};

        // Reset held two cycles with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_done",  32'(done),  32'd0);
        chk("reset_d",     32'(d),     32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcnt, dchg);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("v%0d_busycyc", i), 32'(bcnt), 32'd4);
            chk($sformatf("v%0d_d_stable", i), 32'(dchg), 32'd0);
            chk($sformatf("v%0d_d", i), 32'(d), 32'(vecs[i].d));
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].f));
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // start pulsed mid-RUN is ignored
        @(negedge clk);
        a     = 16'h1234;
        b     = 16'h0234;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a     = 16'h5A5A;
        b     = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        chk("midrun_latency", 32'(n), 32'd1);
        chk("midrun_d", 32'(d), 32'h1000);

        // Back-to-back: start raised during the DONE cycle
        a     = 16'h8000;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_spacing", 32'(n + 1), 32'd5);
        chk("b2b_d", 32'(d), 32'h7FFF);
        chk("b2b_flags", 32'(flags), 32'b00001);

        // Reset after two slices of an op that leaves a pending borrow
        @(posedge clk);
        @(negedge clk);
        a     = 16'h0000;
        b     = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_done",  32'(done),  32'd0);
        chk("abort_d",     32'(d),     32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        run_op(16'h0010, 16'h0001, lat, bcnt, dchg);
        chk("post_abort_latency", 32'(lat), 32'd4);
        chk("post_abort_d", 32'(d), 32'h000F);
        chk("post_abort_flags", 32'(flags), 32'b00010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
